// File: rtl/popcount_word_gen.sv
`default_nettype none
// ============================================================================
// Module      : popcount_word_gen
// Description : Given a bit count K, streams every WIDTH-bit word whose
//               popcount is exactly K, in increasing numeric order, one word
//               per cycle under a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module popcount_word_gen #(
    parameter int WIDTH = 12,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk_i,
    input  logic             arst_i,
    input  logic [CNT_W-1:0] data_i,
    input  logic             data_val_i,
    output logic             rdy_o,
    output logic [WIDTH-1:0] data_o,
    output logic             data_val_o,
    output logic             data_last_o,
    input  logic             data_rdy_i
);

    typedef enum logic [0:0] {
        C_IDLE = 1'b0,
        C_RUN  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] c_width_k  = CNT_W'(WIDTH);
    localparam logic [WIDTH-1:0] c_all_ones = {WIDTH{1'b1}};

    state_t           r_state_q, w_state_d;
    logic [WIDTH-1:0] r_word_q,  w_word_d;
    logic [CNT_W-1:0] r_k_q,     w_k_d;

    logic [CNT_W-1:0] w_k_in;
    logic [WIDTH-1:0] w_first_word;
    logic [WIDTH-1:0] w_low_ones;
    logic [WIDTH-1:0] w_last_word;
    logic [CNT_W-1:0] w_ctz;
    logic [WIDTH:0]   w_x;
    logic [WIDTH:0]   w_c;
    logic [WIDTH:0]   w_r;
    logic [WIDTH:0]   w_next_full;
    logic [WIDTH-1:0] w_next;
    logic             w_last;

    // Clamp the requested count and build its first (smallest) word.
    always_comb begin
        w_k_in       = (data_i > c_width_k) ? c_width_k : data_i;
        w_first_word = ~(c_all_ones << w_k_in);
    end

    // Final word for the latched K: K ones packed against the MSB.
    always_comb begin
        w_low_ones  = ~(c_all_ones << r_k_q);
        w_last_word = w_low_ones << (c_width_k - r_k_q);
        w_last      = (r_state_q == C_RUN) && (r_word_q == w_last_word);
    end

    // Priority encoder: index of the lowest set bit of the current word.
    always_comb begin
        w_ctz = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (r_word_q[i]) begin
                w_ctz = CNT_W'(i);
            end
        end
    end

    // Gosper's hack: next larger word with the same popcount.
    always_comb begin
        w_x         = {1'b0, r_word_q};
        w_c         = w_x & (~w_x + 1'b1);
        w_r         = w_x + w_c;
        w_next_full = w_r | (((w_r ^ w_x) >> 2) >> w_ctz);
        // A carry into bit WIDTH only happens past the final word; hold then.
        w_next      = w_r[WIDTH] ? r_word_q : w_next_full[WIDTH-1:0];
    end

    // Next-state and datapath update for the IDLE/RUN controller.
    always_comb begin
        w_state_d = r_state_q;
        w_word_d  = r_word_q;
        w_k_d     = r_k_q;
        case (r_state_q)
            C_IDLE: begin
                if (data_val_i) begin
                    w_k_d     = w_k_in;
                    w_word_d  = w_first_word;
                    w_state_d = C_RUN;
                end
            end
            C_RUN: begin
                if (data_rdy_i) begin
                    if (w_last) begin
                        w_word_d  = '0;
                        w_state_d = C_IDLE;
                    end else begin
                        w_word_d  = w_next;
                    end
                end
            end
            default: begin
                w_word_d  = '0;
                w_state_d = C_IDLE;
            end
        endcase
    end

    // State and word registers with asynchronous clear.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_state_q <= C_IDLE;
            r_word_q  <= '0;
            r_k_q     <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_word_q  <= w_word_d;
            r_k_q     <= w_k_d;
        end
    end

    // Outputs come straight from registered state so reset clears them at once.
    always_comb begin
        rdy_o       = (r_state_q == C_IDLE);
        data_val_o  = (r_state_q == C_RUN);
        data_o      = r_word_q;
        data_last_o = w_last;
    end

endmodule
`default_nettype wire

// File: tb/tb_popcount_word_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_popcount_word_gen
// Description : Directed self-checking bench for popcount_word_gen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_popcount_word_gen;

    localparam int WIDTH = 12;
    localparam int CNT_W = 4;

    logic             clk;
    logic             arst;
    logic [CNT_W-1:0] data_i;
    logic             data_val_i;
    logic             rdy_o;
    logic [WIDTH-1:0] data_o;
    logic             data_val_o;
    logic             data_last_o;
    logic             data_rdy_i;

    int checks = 0;
    int fails  = 0;

    popcount_word_gen #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk_i       (clk),
        .arst_i      (arst),
        .data_i      (data_i),
        .data_val_i  (data_val_i),
        .rdy_o       (rdy_o),
        .data_o      (data_o),
        .data_val_o  (data_val_o),
        .data_last_o (data_last_o),
        .data_rdy_i  (data_rdy_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: next larger WIDTH-bit value with popcount k (brute force).
    function automatic logic [WIDTH-1:0] next_pop(input logic [WIDTH-1:0] x, input int k);
        for (int v = int'(x) + 1; v < (1 << WIDTH); v++) begin
            if ($countones(v) == k) return WIDTH'(v);
        end
        return '0;
    endfunction

    // Wait for rdy_o with a cycle budget; counts an expiry as a failure.
    task automatic wait_rdy();
        int n;
        n = 0;
        while (rdy_o !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("rdy_wait", {31'd0, rdy_o}, 32'd1);
    endtask

    // Request K, then consume words checking value, valid and last flag.
    // k_eff is the clamped count, n_exp the binomial sequence length.
    task automatic stream(input logic [CNT_W-1:0] k_req, input int k_eff, input int n_exp,
                          input bit bp, input int stop_after, input int pulse_at,
                          input logic [WIDTH-1:0] last_word);
        logic [WIDTH-1:0] exp;
        logic [WIDTH-1:0] last_obs;
        logic             r;
        int               cnt;
        int               cyc;
        wait_rdy();
        data_i     = k_req;
        data_val_i = 1'b1;
        @(posedge clk); #1;
        data_val_i = 1'b0;
        data_i     = '0;
        exp      = WIDTH'((1 << k_eff) - 1);
        last_obs = '0;
        cnt      = 0;
        cyc      = 0;
        while (cnt < n_exp && cnt < stop_after && cyc < 20000) begin
            r          = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            data_rdy_i = r;
            if (cnt == pulse_at) begin
                data_i     = 4'd3;
                data_val_i = 1'b1;
            end
            check("val",  {31'd0, data_val_o}, 32'd1);
            check("rdy",  {31'd0, rdy_o}, 32'd0);
            check("word", {20'd0, data_o}, {20'd0, exp});
            check("last", {31'd0, data_last_o}, {31'd0, (cnt == n_exp - 1)});
            if (r) last_obs = data_o;
            @(posedge clk); #1;
            data_val_i = 1'b0;
            data_i     = '0;
            cyc++;
            if (r) begin
                cnt++;
                if (cnt < n_exp) exp = next_pop(exp, k_eff);
            end
        end
        check("cycle_budget", {31'd0, (cyc < 20000)}, 32'd1);
        if (cnt == n_exp) begin
            check("final_word", {20'd0, last_obs}, {20'd0, last_word});
            check("idle_rdy", {31'd0, rdy_o}, 32'd1);
            check("idle_val", {31'd0, data_val_o}, 32'd0);
        end
        data_rdy_i = 1'b1;
    endtask

    initial begin
        arst       = 1'b1;
        data_i     = '0;
        data_val_i = 1'b0;
        data_rdy_i = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        check("rst_rdy",  {31'd0, rdy_o}, 32'd1);
        check("rst_val",  {31'd0, data_val_o}, 32'd0);
        check("rst_data", {20'd0, data_o}, 32'd0);
        check("rst_last", {31'd0, data_last_o}, 32'd0);
        arst = 1'b0;
        @(posedge clk); #1;

        // Asynchronous reset mid-cycle while a K=5 run is active.
        data_i = 4'd5; data_val_i = 1'b1; data_rdy_i = 1'b0;
        @(posedge clk); #1;
        data_val_i = 1'b0;
        check("run_word5", {20'd0, data_o}, 32'h01F);
        #2 arst = 1'b1;
        #1;
        check("arst_rdy",  {31'd0, rdy_o}, 32'd1);
        check("arst_val",  {31'd0, data_val_o}, 32'd0);
        check("arst_data", {20'd0, data_o}, 32'd0);
        check("arst_last", {31'd0, data_last_o}, 32'd0);
        @(posedge clk); #1;
        arst = 1'b0;
        data_rdy_i = 1'b1;
        @(posedge clk); #1;

        // K=2, no backpressure: 66 words ending in 0xC00.
        stream(4'd2, 2, 66, 1'b0, 100000, -1, 12'hC00);
        // Boundaries.
        stream(4'd0, 0, 1, 1'b0, 100000, -1, 12'h000);
        stream(4'd12, 12, 1, 1'b0, 100000, -1, 12'hFFF);
        stream(4'd15, 12, 1, 1'b0, 100000, -1, 12'hFFF);
        // K=6 with random backpressure: 924 words ending in 0xFC0.
        stream(4'd6, 6, 924, 1'b1, 100000, -1, 12'hFC0);
        // K=1 with an ignored K=3 request pulsed mid-run.
        stream(4'd1, 1, 12, 1'b0, 100000, 3, 12'h800);
        repeat (3) begin
            @(posedge clk); #1;
            check("no_k3_val", {31'd0, data_val_o}, 32'd0);
        end

        // K=6 interrupted by reset after 100 words, then K=1.
        stream(4'd6, 6, 924, 1'b0, 100, -1, 12'hFC0);
        check("pre_rst_val", {31'd0, data_val_o}, 32'd1);
        #2 arst = 1'b1;
        #1;
        check("mid_rst_val",  {31'd0, data_val_o}, 32'd0);
        check("mid_rst_data", {20'd0, data_o}, 32'd0);
        check("mid_rst_rdy",  {31'd0, rdy_o}, 32'd1);
        @(posedge clk); #1;
        arst = 1'b0;
        @(posedge clk); #1;
        stream(4'd1, 1, 12, 1'b0, 100000, -1, 12'h800);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/popcount_word_gen.md
Name: popcount_word_gen

Overview:
- Inverse of the population-count block: accepts a bit count K and streams every WIDTH-bit word whose popcount is exactly K.
- Words are produced in strictly increasing numeric order, one per cycle, under a valid/ready handshake.
- Used as a stimulus source and as a sparse-mask enumerator feeding the popcount datapath.

Parameters:
- WIDTH, 12, output word width (>= 2)
- CNT_W, $clog2(WIDTH+1), width of the count input; must represent 0..WIDTH inclusive

Ports:
- clk_i  in  1  clock, rising edge
- arst_i  in  1  reset, asynchronous, active-high
- data_i  in  CNT_W  requested bit count K
- data_val_i  in  1  K valid; accepted only when rdy_o=1
- rdy_o  out  1  block idle and able to accept a new K
- data_o  out  WIDTH  generated word
- data_val_o  out  1  data_o valid
- data_last_o  out  1  data_o is the final word for the current K; qualified by data_val_o
- data_rdy_i  in  1  downstream accepts data_o

Behaviour:
- Reset, asynchronous, arst_i=1:
  - state=IDLE immediately; data_o=0, data_val_o=0, data_last_o=0, rdy_o=1.
  - Holds while arst_i is high. An in-flight sequence is discarded.
- FSM states: IDLE, RUN.
- IDLE:
  - rdy_o=1, data_val_o=0.
  - On a clock edge with data_val_i=1, latch K; go to RUN.
  - K > WIDTH is clamped to WIDTH.
- First word:
  - Registered as (1<<K)-1 on the accept edge.
  - data_val_o=1 from that edge onward: one-cycle latency from acceptance to first valid.
- RUN:
  - rdy_o=0. data_val_i is ignored and not queued.
  - data_o, data_val_o and data_last_o hold stable while data_val_o=1 and data_rdy_i=0.
- Advance on data_val_o & data_rdy_i:
  - If data_last_o=0, load the next word.
  - If data_last_o=1, go to IDLE: data_val_o=0 and rdy_o=1 on that same edge. A new K can be accepted on the following edge.
  - There are no gap cycles between words while data_rdy_i stays high.
- Next-word rule, Gosper, x = current word:
  - c = x & (~x+1); r = x + c; next = r | (((r ^ x) >> 2) >> ctz(x)).
  - ctz(x) comes from a priority encoder on x.
  - Arithmetic is WIDTH+1 bits wide. The carry out never reaches bit WIDTH for non-last words.
- data_last_o:
  - Combinational compare: data_o == ((1<<K)-1) << (WIDTH-K).
  - For K=0 the only word is 0, so data_last_o=1 on that word.
  - For K=WIDTH the only word is all-ones, so data_last_o=1 on that word.
- Sequence length: exactly C(WIDTH,K) words.
  - Each word appears exactly once, and each word is strictly greater than the previous one.
- No output ever has popcount != K.

Test Plan:
- Reset: assert arst_i mid-cycle with no clock edge -> data_val_o=0, data_o=0, data_last_o=0 and rdy_o=1 immediately.
- K=2, data_rdy_i=1 throughout -> 66 consecutive words:
  - first four are 0x003, 0x005, 0x006, 0x009;
  - 66th is 0xC00 with data_last_o=1 (only there);
  - rdy_o=1 on the next cycle.
- Boundaries, each producing one word with data_last_o=1, then IDLE:
  - K=0 -> word 0x000;
  - K=12 -> word 0xFFF;
  - K=15 (clamped) -> word 0xFFF.
- Backpressure: K=6 with data_rdy_i randomly toggled -> 924 transfers:
  - each word has popcount 6 and is strictly increasing;
  - data_o is stable during every stall;
  - the last word is 0xFC0.
- Ignored input: pulse data_val_i with K=3 during a K=1 run -> the run still emits 0x001, 0x002, ... 0x800 (12 words), with no K=3 words afterward.
- Reset mid-run: assert arst_i after 100 words of K=6 -> outputs clear asynchronously. After release, K=1 -> 12 words starting at 0x001.
